// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets,
// TCR/TSR bit positions, clock-select encoding and the per-channel mode decode.
// No logic of its own; imported by timer_ch and timer_multi_ch.
package timer_pkg;

  // Register offsets within a channel's 4-byte window
  localparam logic [1:0] TDR_OFF  = 2'd0;
  localparam logic [1:0] TCR_OFF  = 2'd1;
  localparam logic [1:0] TSR_OFF  = 2'd2;
  localparam logic [1:0] TCNT_OFF = 2'd3;

  // TCR bit indices
  localparam int TCR_LOAD   = 7;
  localparam int TCR_AR     = 6;
  localparam int TCR_DOWN   = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_UDF_IE = 3;
  localparam int TCR_OVF_IE = 2;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // TSR bit indices
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Tick source selected by TCR[1:0]
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // Counter operating mode
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2
  } mode_e;

  // Load has priority over enable
  function automatic mode_e tcr_mode(input logic load, input logic en);
    if (load)    return MODE_LOAD;
    else if (en) return MODE_RUN;
    else         return MODE_IDLE;
  endfunction

endpackage

// File: rtl/timer_multi_ch_if.sv
// APB slave bus bundle for timer_multi_ch (psel/penable/pwrite/paddr/pwdata in,
// prdata/pready/pslverr out). Zero-latency, no backpressure (pready tied high).
// DW: data width, matches the timer's CNT_W.
interface timer_multi_ch_if #(
  parameter int DW = 8
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [7:0]    paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_ch.sv
// One timer channel: TDR/TCR/TSR/TCNT registers, up/down counter, sticky flags, irq.
// Latency: register writes land on the commit edge; irq is registered one cycle after its flag.
// Backpressure: none; writes are always accepted. Ports: clk/rst_n, shared tick_vec,
// wr_en/wr_off/wr_dat write strobe, rd_off/rd_dat combinational read, irq out.
module timer_ch
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       tick_vec,
  input  logic             wr_en,
  input  logic [1:0]       wr_off,
  input  logic [CNT_W-1:0] wr_dat,
  input  logic [1:0]       rd_off,
  output logic [CNT_W-1:0] rd_dat,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] tdr_q, tdr_d;
  logic [7:0]       tcr_q, tcr_d;
  logic [1:0]       tsr_q, tsr_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             irq_q, irq_d;

  // The mode register is TCR itself, so the next-state process below only
  // decodes it; the count state lives in tcnt_q.
  mode_e mode;
  cks_e  cks;
  logic  tick;
  logic  ovf_set, udf_set;
  logic [1:0] clr_keep;

  assign mode = tcr_mode(tcr_q[TCR_LOAD], tcr_q[TCR_EN]);
  assign cks  = cks_e'(tcr_q[TCR_CKS_HI:TCR_CKS_LO]);
  assign tick = tick_vec[cks];

  always_comb begin
    tdr_d    = tdr_q;
    tcr_d    = tcr_q;
    tcnt_d   = tcnt_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    clr_keep = 2'b11;

    if (wr_en) begin
      unique case (wr_off)
        TDR_OFF: tdr_d    = wr_dat;
        TCR_OFF: tcr_d    = wr_dat[7:0];
        TSR_OFF: clr_keep = wr_dat[1:0];  // bits written 0 are cleared
        default: ;
      endcase
    end

    unique case (mode)
      MODE_LOAD: tcnt_d = tdr_q;
      MODE_RUN: begin
        if (tick) begin
          if (tcr_q[TCR_DOWN]) begin
            if (tcnt_q == '0) begin
              tcnt_d  = tcr_q[TCR_AR] ? tdr_q : CNT_MAX;
              udf_set = 1'b1;
            end else begin
              tcnt_d = tcnt_q - CNT_ONE;
            end
          end else begin
            if (tcnt_q == CNT_MAX) begin
              tcnt_d  = tcr_q[TCR_AR] ? tdr_q : '0;
              ovf_set = 1'b1;
            end else begin
              tcnt_d = tcnt_q + CNT_ONE;
            end
          end
        end
      end
      default: ;
    endcase

    // Hardware set is ORed after the clear so a same-cycle set wins
    tsr_d = (tsr_q & clr_keep) | {udf_set, ovf_set};

    irq_d = (tsr_q[TSR_OVF] & tcr_q[TCR_OVF_IE]) |
            (tsr_q[TSR_UDF] & tcr_q[TCR_UDF_IE]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tsr_q  <= '0;
      tcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tsr_q  <= tsr_d;
      tcnt_q <= tcnt_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_dat = '0;
    unique case (rd_off)
      TDR_OFF:  rd_dat = tdr_q;
      TCR_OFF:  rd_dat = CNT_W'(tcr_q);
      TSR_OFF:  rd_dat = CNT_W'(tsr_q);
      TCNT_OFF: rd_dat = tcnt_q;
      default:  ;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/timer_multi_ch.sv
// CH_NUM-channel APB timer: address decode, read mux, shared prescaler, irq OR.
// Latency: zero-wait APB (pready=1); reads combinational in the access phase.
// Backpressure: none. Ports: pclk, presetn, apb slave bundle, irq[CH_NUM], irq_any.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 4
) (
  input  logic              pclk,
  input  logic              presetn,
  timer_multi_ch_if.slave   apb,
  output logic [CH_NUM-1:0] irq,
  output logic              irq_any
);

  logic [5:0] ch_idx;
  logic [1:0] reg_off;
  logic       ch_ok;
  logic       access;
  logic       wr_ok;
  logic       rd_ok;

  assign ch_idx  = apb.paddr[7:2];
  assign reg_off = apb.paddr[1:0];
  assign ch_ok   = (int'(ch_idx) < CH_NUM);
  assign access  = apb.psel & apb.penable;
  assign wr_ok   = access & apb.pwrite & ch_ok & (reg_off != TCNT_OFF);
  assign rd_ok   = access & ~apb.pwrite & ch_ok;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & (~ch_ok | (apb.pwrite & (reg_off == TCNT_OFF)));

  // Free-running prescaler; a tick is the cycle right after a bit rises
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] presc_prev_q, presc_prev_d;
  logic [DIV_W-1:0] tick_edge;
  logic [3:0]       tick_sel;

  always_comb begin
    presc_d      = presc_q + 1'b1;
    presc_prev_d = presc_q;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      presc_q      <= '0;
      presc_prev_q <= '0;
    end else begin
      presc_q      <= presc_d;
      presc_prev_q <= presc_prev_d;
    end
  end

  assign tick_edge = presc_q & ~presc_prev_q;

  // cks can name a divider the prescaler is too narrow for; that source never ticks
  for (genvar k = 0; k < 4; k++) begin : g_tick
    if (k < DIV_W) begin : g_on
      assign tick_sel[k] = tick_edge[k];
    end else begin : g_off
      assign tick_sel[k] = 1'b0;
    end
  end

  logic [CNT_W-1:0] rd_dat [CH_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (pclk),
      .rst_n    (presetn),
      .tick_vec (tick_sel),
      .wr_en    (wr_ok && (ch_idx == 6'(c))),
      .wr_off   (reg_off),
      .wr_dat   (apb.pwdata),
      .rd_off   (reg_off),
      .rd_dat   (rd_dat[c]),
      .irq      (irq[c])
    );
  end

  logic [CNT_W-1:0] rdata_mux;

  always_comb begin
    rdata_mux = '0;
    if (rd_ok) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch_idx == 6'(c)) rdata_mux = rd_dat[c];
      end
    end
  end

  assign apb.prdata = rdata_mux;
  assign irq_any    = |irq;

endmodule
